// File: rtl/mx_block_scale_stream.sv
// Block-scaling front end for MX quantisation: buffers one block of signed elements,
// derives the shared E8M0 scale from the largest magnitude, then replays sign/magnitude.
module mx_block_scale_stream #(
  parameter int unsigned width_i      = 8,
  parameter int unsigned block_size   = 32,
  parameter int unsigned width_shift  = 8,
  parameter int          scale_offset = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [width_i-1:0]     i_num,
  input  logic                   i_nan,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [width_i-1:0]     o_num,
  output logic                   o_sign,
  output logic                   o_nan,
  output logic [width_shift-1:0] o_shift,
  output logic [7:0]             o_scale,
  output logic                   o_first,
  output logic                   o_last
);

  localparam int unsigned CntW = $clog2(block_size);
  localparam logic [width_i-1:0] MagMax = {1'b0, {(width_i-1){1'b1}}};
  localparam logic [CntW-1:0] CntLast = CntW'(block_size - 1);

  typedef enum logic [1:0] {StFill, StCalc, StDrain} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0]        wr_cnt_q, rd_cnt_q;
  logic [width_i-1:0]     max_q;
  logic                   nan_any_q;
  logic [width_shift-1:0] shift_q, shift_calc;
  logic [7:0]             scale_q, scale_calc;

  logic [width_i-1:0] mem_num  [block_size];
  logic               mem_sign [block_size];
  logic               mem_nan  [block_size];

  logic               accept, out_hs, wr_last, rd_last;
  logic [width_i-1:0] neg_num, in_mag;
  int                 msb_idx, scale_raw;

  assign o_ready = (state_q == StFill);
  assign o_valid = (state_q == StDrain);
  assign accept  = i_valid && o_ready;
  assign out_hs  = o_valid && i_ready;
  assign wr_last = (wr_cnt_q == CntLast);
  assign rd_last = (rd_cnt_q == CntLast);

  // Most negative input has no positive twin; it saturates to the largest magnitude.
  always_comb begin
    neg_num = '0 - i_num;
    in_mag  = i_num;
    if (i_num[width_i-1]) begin
      in_mag = neg_num[width_i-1] ? MagMax : neg_num;
    end
  end

  always_comb begin
    msb_idx = 0;
    for (int i = 0; i < int'(width_i); i++) begin
      if (max_q[i]) msb_idx = i;
    end
    scale_raw = 127 + msb_idx + scale_offset;
    if (scale_raw < 0) scale_raw = 0;
    if (scale_raw > 254) scale_raw = 254;
    shift_calc = width_shift'(int'(width_i) - 1 - msb_idx);
    scale_calc = 8'(scale_raw);
    if (max_q == '0) begin
      shift_calc = '0;
      scale_calc = '0;
    end
    if (nan_any_q) scale_calc = 8'hFF;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (accept && wr_last) state_d = StCalc;
      StCalc:  state_d = StDrain;
      StDrain: if (out_hs && rd_last) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StFill;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      max_q     <= '0;
      nan_any_q <= 1'b0;
      shift_q   <= '0;
      scale_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
        if (i_nan) begin
          nan_any_q <= 1'b1;
        end else if (in_mag > max_q) begin
          max_q <= in_mag;
        end
      end
      if (state_q == StCalc) begin
        shift_q <= shift_calc;
        scale_q <= scale_calc;
      end
      if (out_hs) begin
        rd_cnt_q <= rd_last ? '0 : rd_cnt_q + 1'b1;
        if (rd_last) begin
          max_q     <= '0;
          nan_any_q <= 1'b0;
        end
      end
    end
  end

  // NaN/Inf payloads are kept verbatim with a cleared sign.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem_num[wr_cnt_q]  <= i_nan ? i_num : in_mag;
      mem_sign[wr_cnt_q] <= i_nan ? 1'b0 : i_num[width_i-1];
      mem_nan[wr_cnt_q]  <= i_nan;
    end
  end

  assign o_num   = o_valid ? mem_num[rd_cnt_q] : '0;
  assign o_sign  = o_valid ? mem_sign[rd_cnt_q] : 1'b0;
  assign o_nan   = o_valid ? mem_nan[rd_cnt_q] : 1'b0;
  assign o_first = o_valid && (rd_cnt_q == '0);
  assign o_last  = o_valid && rd_last;
  assign o_shift = shift_q;
  assign o_scale = scale_q;

endmodule

// File: tb/tb_mx_block_scale_stream.sv
// Randomised bench for mx_block_scale_stream with a block-level reference model
// and a few directed blocks whose results are pinned to hand-computed values.
module tb_mx_block_scale_stream;

  localparam int BS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_num = '0;
  logic       i_nan = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_ready, o_valid, o_sign, o_nan, o_first, o_last;
  logic [7:0] o_num, o_shift, o_scale;

  mx_block_scale_stream #(
    .width_i      (8),
    .block_size   (BS),
    .width_shift  (8),
    .scale_offset (0)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_num   (i_num),
    .i_nan   (i_nan),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_num   (o_num),
    .o_sign  (o_sign),
    .o_nan   (o_nan),
    .o_shift (o_shift),
    .o_scale (o_scale),
    .o_first (o_first),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] num;
    logic       nan;
  } elem_t;

  typedef struct {
    logic [7:0] num;
    logic       sign;
    logic       nan;
    logic [7:0] shift;
    logic [7:0] scale;
    logic       first;
    logic       last;
  } beat_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    last_acc_cyc = 0;
  bit    calc_wait = 0;
  bit    prev_valid = 0;
  bit    rand_ready = 0;
  elem_t blk[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    lat_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: block max over finite elements, floor(log2) for the exponent.
  function automatic void build_block();
    int mx = 0;
    bit na = 0;
    int p, sh, sc, v, mag;
    beat_t b;
    foreach (blk[i]) begin
      v   = int'($signed(blk[i].num));
      mag = (v < 0) ? ((-v > 127) ? 127 : -v) : v;
      if (blk[i].nan) na = 1;
      else if (mag > mx) mx = mag;
    end
    if (mx == 0) begin
      sh = 0;
      sc = 0;
    end else begin
      p  = $clog2(mx + 1) - 1;
      sh = 7 - p;
      sc = 127 + p;
      if (sc > 254) sc = 254;
    end
    if (na) sc = 255;
    foreach (blk[i]) begin
      v   = int'($signed(blk[i].num));
      mag = (v < 0) ? ((-v > 127) ? 127 : -v) : v;
      b.num   = blk[i].nan ? blk[i].num : 8'(mag);
      b.sign  = blk[i].nan ? 1'b0 : (v < 0);
      b.nan   = blk[i].nan;
      b.shift = 8'(sh);
      b.scale = 8'(sc);
      b.first = (i == 0);
      b.last  = (i == BS - 1);
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    bit    exp_ready, exp_valid;
    beat_t g;
    elem_t e;
    cyc++;
    if (rst) begin
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_num", 32'(o_num), 32'd0);
      chk("rst_o_shift", 32'(o_shift), 32'd0);
      chk("rst_o_scale", 32'(o_scale), 32'd0);
      chk("rst_o_flags", 32'({o_sign, o_nan, o_first, o_last}), 32'd0);
      blk.delete();
      exp_q.delete();
      calc_wait  = 0;
      prev_valid = 0;
    end else begin
      exp_ready = (exp_q.size() == 0);
      exp_valid = !exp_ready && !calc_wait;
      chk("o_ready", 32'(o_ready), 32'(exp_ready));
      chk("o_valid", 32'(o_valid), 32'(exp_valid));
      if (o_valid && !prev_valid) lat_q.push_back(cyc - last_acc_cyc);
      prev_valid = o_valid;
      calc_wait  = 0;
      if (o_valid && exp_valid) begin
        chk("o_num", 32'(o_num), 32'(exp_q[0].num));
        chk("o_sign", 32'(o_sign), 32'(exp_q[0].sign));
        chk("o_nan", 32'(o_nan), 32'(exp_q[0].nan));
        chk("o_shift", 32'(o_shift), 32'(exp_q[0].shift));
        chk("o_scale", 32'(o_scale), 32'(exp_q[0].scale));
        chk("o_first", 32'(o_first), 32'(exp_q[0].first));
        chk("o_last", 32'(o_last), 32'(exp_q[0].last));
        if (i_ready) begin
          g.num   = o_num;
          g.sign  = o_sign;
          g.nan   = o_nan;
          g.shift = o_shift;
          g.scale = o_scale;
          g.first = o_first;
          g.last  = o_last;
          got_q.push_back(g);
          void'(exp_q.pop_front());
        end
      end
      if (i_valid && exp_ready) begin
        e.num = i_num;
        e.nan = i_nan;
        blk.push_back(e);
        if (blk.size() == BS) begin
          build_block();
          blk.delete();
          calc_wait    = 1;
          last_acc_cyc = cyc;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    i_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic push(input logic [7:0] n, input logic nn);
    int waited = 0;
    bit acc;
    i_valid = 1'b1;
    i_num   = n;
    i_nan   = nn;
    do begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      waited++;
      if (waited > 200) begin
        chk("push_timeout", 32'd1, 32'd0);
        break;
      end
    end while (!acc);
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 500);
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string name, input int idx, input int num, input int sign,
                          input int nan, input int shift, input int scale);
    chk({name, "_num"}, 32'(got_q[idx].num), 32'(num));
    chk({name, "_sign"}, 32'(got_q[idx].sign), 32'(sign));
    chk({name, "_nan"}, 32'(got_q[idx].nan), 32'(nan));
    chk({name, "_shift"}, 32'(got_q[idx].shift), 32'(shift));
    chk({name, "_scale"}, 32'(got_q[idx].scale), 32'(scale));
  endtask

  task automatic rand_elem();
    int r = $urandom_range(0, 19);
    int sh = $urandom_range(0, 8);
    logic [7:0] v = 8'($urandom) >> sh;
    if (r == 0) push(8'($urandom), 1'b1);
    else if (r == 1) push(8'h80, 1'b0);
    else if (r == 2) push(8'h00, 1'b0);
    else push(($urandom_range(0, 1) != 0) ? -v : v, 1'b0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    base = got_q.size();
    push(8'd3, 1'b0);
    push(8'hFB, 1'b0);
    push(8'd12, 1'b0);
    push(8'd1, 1'b0);
    wait_drain();
    chk("blk1_count", 32'(got_q.size() - base), 32'd4);
    if (got_q.size() - base == 4) begin
      chk_beat("blk1_b0", base, 3, 0, 0, 4, 130);
      chk_beat("blk1_b1", base + 1, 5, 1, 0, 4, 130);
      chk_beat("blk1_b2", base + 2, 12, 0, 0, 4, 130);
      chk_beat("blk1_b3", base + 3, 1, 0, 0, 4, 130);
      chk("blk1_first", 32'({got_q[base].first, got_q[base + 3].first}), 32'b10);
      chk("blk1_last", 32'({got_q[base].last, got_q[base + 3].last}), 32'b01);
    end
    chk("blk1_latency", 32'(lat_q[$]), 32'd2);

    base = got_q.size();
    push(8'h80, 1'b0);
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    wait_drain();
    chk("minval_count", 32'(got_q.size() - base), 32'd4);
    if (got_q.size() - base == 4) chk_beat("minval_b0", base, 127, 1, 0, 1, 133);

    base = got_q.size();
    repeat (BS) push(8'h00, 1'b0);
    wait_drain();
    chk("zeros_count", 32'(got_q.size() - base), 32'd4);
    if (got_q.size() - base == 4) begin
      chk_beat("zeros_b0", base, 0, 0, 0, 0, 0);
      chk_beat("zeros_b3", base + 3, 0, 0, 0, 0, 0);
    end

    base = got_q.size();
    push(8'h7F, 1'b1);
    push(8'd1, 1'b0);
    push(8'd2, 1'b0);
    push(8'd4, 1'b0);
    wait_drain();
    chk("nan_count", 32'(got_q.size() - base), 32'd4);
    if (got_q.size() - base == 4) begin
      chk_beat("nan_b0", base, 8'h7F, 0, 1, 5, 8'hFF);
      chk_beat("nan_b3", base + 3, 4, 0, 0, 5, 8'hFF);
    end

    // Partial block is thrown away by reset; only the fresh elements come out.
    push(8'd100, 1'b0);
    push(8'h90, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = got_q.size();
    repeat (32) rand_elem();
    wait_drain();
    chk("midrst_count", 32'(got_q.size() - base), 32'd32);

    rand_ready = 1;
    base = got_q.size();
    for (int b = 0; b < 100; b++) begin
      for (int k = 0; k < BS; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        rand_elem();
      end
    end
    wait_drain();
    chk("rand_count", 32'(got_q.size() - base), 32'(100 * BS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
